// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller and observer for a processor core.
// It sequences the core's active-low reset, counts RUN cycles, ends the run
// on a cycle budget or on a PC-stability halt, and snapshots NUM_REGS
// register channels when the run ends.
//
// Optional feature macro: CPU_RUN_MONITOR_HALT_DETECT_EN
//   defined   -> PC-stability halt detection is active
//   undefined -> runs end only on the cycle budget; `halted` stays 0, `pc` is unused
//
// Handshake: `start` is a level that is sampled only in IDLE and DONE; `done`
// is a registered level that stays high for as long as the block is in DONE.
`timescale 1ns/1ps

module cpu_run_monitor #(
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int MAX_CYCLES   = 2000,
    parameter int RESET_CYCLES = 2,
    parameter int HALT_STABLE  = 4,
    parameter int NUM_REGS     = 6,
    parameter int REG_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PC_WIDTH-1:0]           pc,
    input  logic [NUM_REGS*REG_WIDTH-1:0] regs_in,
    output logic                          cpu_rst,
    output logic [1:0]                    state,
    output logic [CNT_WIDTH-1:0]          cycles_consumed,
    output logic                          done,
    output logic                          timeout,
    output logic                          halted,
    output logic [NUM_REGS*REG_WIDTH-1:0] snap_regs
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // The reset counter only has to hold RESET_CYCLES-1
    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0]       RST_LOAD = RCW'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_CYCLES);

    state_e                          state_q, state_d;
    logic [RCW-1:0]                  rst_cnt_q, rst_cnt_d;
    logic [CNT_WIDTH-1:0]            cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]            cycles_inc;
    logic                            cpu_rst_q, cpu_rst_d;
    logic                            done_q, done_d;
    logic                            timeout_q, timeout_d;
    logic                            halted_q, halted_d;
    logic [NUM_REGS*REG_WIDTH-1:0]   snap_q, snap_d;
    logic                            halt_hit;

    assign cycles_inc = cycles_q + CNT_WIDTH'(1);

`ifdef CPU_RUN_MONITOR_HALT_DETECT_EN
    localparam int SCW = $clog2(HALT_STABLE + 1);
    localparam logic [SCW-1:0] HALT_CNT = SCW'(HALT_STABLE);

    logic [PC_WIDTH-1:0] pc_prev_q, pc_prev_d;
    logic                pc_prev_vld_q, pc_prev_vld_d;
    logic [SCW-1:0]      stable_cnt_q, stable_cnt_d;

    // PC-stability tracking: only active in RUN, re-armed outside it so every
    // run starts with an invalid previous PC and a zero stability count
    always_comb begin
        pc_prev_d     = pc_prev_q;
        pc_prev_vld_d = 1'b0;
        stable_cnt_d  = '0;
        halt_hit      = 1'b0;
        if (state_q == ST_RUN) begin
            pc_prev_d     = pc;
            pc_prev_vld_d = 1'b1;
            if (pc_prev_vld_q && (pc == pc_prev_q)) begin
                stable_cnt_d = stable_cnt_q + SCW'(1);
            end
            halt_hit = (stable_cnt_d == HALT_CNT);
        end
    end

    // Halt-detection state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_prev_q     <= '0;
            pc_prev_vld_q <= 1'b0;
            stable_cnt_q  <= '0;
        end else begin
            pc_prev_q     <= pc_prev_d;
            pc_prev_vld_q <= pc_prev_vld_d;
            stable_cnt_q  <= stable_cnt_d;
        end
    end
`else
    // Without halt detection the PC is not observed at all
    logic unused_pc;
    assign unused_pc = ^pc;
    assign halt_hit  = 1'b0;
`endif

    // Run sequencer: next state, counters, flags and snapshot
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cycles_d  = cycles_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        halted_d  = halted_q;
        snap_d    = snap_q;
        unique case (state_q)
            ST_IDLE: begin
                cpu_rst_d = 1'b0;
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RST_LOAD;
                    cycles_d  = '0;
                end
            end
            ST_RESET: begin
                cpu_rst_d = 1'b0;
                if (rst_cnt_q == '0) begin
                    state_d   = ST_RUN;
                    cpu_rst_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q - RCW'(1);
                end
            end
            ST_RUN: begin
                cpu_rst_d = 1'b1;
                cycles_d  = cycles_inc;
                // Halt takes priority when both end conditions hit together
                if (halt_hit) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    halted_d = 1'b1;
                    snap_d   = regs_in;
                end else if (cycles_inc == MAX_CNT) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    snap_d    = regs_in;
                end
            end
            ST_DONE: begin
                // Core keeps running out of reset; its cycles are not counted
                cpu_rst_d = 1'b1;
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RST_LOAD;
                    cycles_d  = '0;
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    halted_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset drops the core reset asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rst_cnt_q <= '0;
            cycles_q  <= '0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
            snap_q    <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cycles_q  <= cycles_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            halted_q  <= halted_d;
            snap_q    <= snap_d;
        end
    end

    assign state           = state_q;
    assign cpu_rst         = cpu_rst_q;
    assign cycles_consumed = cycles_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign halted          = halted_q;
    assign snap_regs       = snap_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Testbench for cpu_run_monitor: directed runs with hand-computed end points.
// A driver issues each run and pushes its expected end record; a monitor pops
// and compares whenever `done` rises.
`timescale 1ns/1ps

module tb_cpu_run_monitor;
  localparam int PCW  = 32;
  localparam int CW   = 32;
  localparam int MAXC = 10;
  localparam int RSTC = 2;
  localparam int HS   = 4;
  localparam int NR   = 6;
  localparam int RW   = 32;
  localparam int SNW  = NR * RW;
  localparam int EXPW = CW + 2 + SNW;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [PCW-1:0] pc;
  logic [SNW-1:0] regs_in;
  logic           cpu_rst;
  logic [1:0]     state;
  logic [CW-1:0]  cycles_consumed;
  logic           done;
  logic           timeout;
  logic           halted;
  logic [SNW-1:0] snap_regs;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .PC_WIDTH(PCW), .CNT_WIDTH(CW), .MAX_CYCLES(MAXC), .RESET_CYCLES(RSTC),
    .HALT_STABLE(HS), .NUM_REGS(NR), .REG_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .regs_in(regs_in),
    .cpu_rst(cpu_rst), .state(state), .cycles_consumed(cycles_consumed),
    .done(done), .timeout(timeout), .halted(halted), .snap_regs(snap_regs)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EXPW-1:0] exp_q[$];
  logic [SNW-1:0]  last_snap = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Register channel k during RUN cycle c of run r = {r, k, c}
  function automatic logic [SNW-1:0] reg_vec(input int run_id, input int cyc);
    logic [SNW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) begin
      v[k*RW +: RW] = {8'(run_id), 8'(k), 16'(cyc)};
    end
    return v;
  endfunction

  // PC presented during RUN cycle c (1-based) for each stimulus pattern
  function automatic logic [PCW-1:0] pc_at(input int mode, input int c);
    case (mode)
      0:       return PCW'(4 * c);                          // always moving
      1:       return (c <= 4) ? PCW'(4 * (c - 1)) : 32'd12; // 0,4,8,12,12...
      2:       return (c <= 6) ? PCW'(4 * c) : 32'd24;       // settles at cycle 6
      default: return 32'h100;                               // constant
    endcase
  endfunction

  // Monitor: compare the end-of-run record each time done rises
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    logic [EXPW-1:0] e;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: actual=done required=no_run_pending");
      end else begin
        e = exp_q.pop_front();
        check("end_cycles",  cycles_consumed, e[EXPW-1 -: CW]);
        check("end_timeout", timeout,         e[SNW+1]);
        check("end_halted",  halted,          e[SNW]);
        check("end_snap",    snap_regs,       e[SNW-1:0]);
        check("end_state",   state,           2'd3);
      end
    end
    done_prev = done;
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT in IDLE or DONE.
  task automatic do_run(input int run_id, input int mode, input int exp_cyc,
                        input bit exp_t, input bit exp_h, input bit from_done,
                        input bit hold_start);
    logic [SNW-1:0] exp_snap;
    bit seen;
    exp_snap = reg_vec(run_id, exp_cyc);
    exp_q.push_back({CW'(exp_cyc), exp_t, exp_h, exp_snap});
    start = 1'b1;
    @(negedge clk);
    check("rst_state",   state,           2'd1);
    check("rst_cpu_rst", cpu_rst,         1'b0);
    check("rst_cycles",  cycles_consumed, 0);
    if (from_done) begin
      check("restart_done",    done,      1'b0);
      check("restart_timeout", timeout,   1'b0);
      check("restart_halted",  halted,    1'b0);
      check("restart_snap",    snap_regs, last_snap);
    end
    if (!hold_start) start = 1'b0;
    @(negedge clk);
    check("rst_hold_state",   state,   2'd1);
    check("rst_hold_cpu_rst", cpu_rst, 1'b0);
    @(negedge clk);
    check("run_entry_state",   state,           2'd2);
    check("run_entry_cpu_rst", cpu_rst,         1'b1);
    check("run_entry_cycles",  cycles_consumed, 0);
    seen = 1'b0;
    pc = pc_at(mode, 1);
    regs_in = reg_vec(run_id, 1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check("run_count", cycles_consumed, c);
      if (done) begin
        seen = 1'b1;
        break;
      end
      pc = pc_at(mode, c + 1);
      regs_in = reg_vec(run_id, c + 1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL run_end_wait: actual=no_done required=done_within_40");
    end
    last_snap = exp_snap;
    pc = pc + 32'd4;
    regs_in = reg_vec(run_id, 99);
    @(negedge clk);
    if (hold_start) begin
      check("held_restart_state",  state,           2'd1);
      check("held_restart_done",   done,            1'b0);
      check("held_restart_cycles", cycles_consumed, 0);
      start = 1'b0;
    end else begin
      check("done_hold_cycles",  cycles_consumed, exp_cyc);
      check("done_hold_done",    done,            1'b1);
      check("done_hold_cpu_rst", cpu_rst,         1'b1);
      check("done_hold_snap",    snap_regs,       exp_snap);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    start = 1'b0;
    pc = '0;
    regs_in = '0;
    repeat (3) @(negedge clk);
    check("reset_state",   state,           2'd0);
    check("reset_cpu_rst", cpu_rst,         1'b0);
    check("reset_cycles",  cycles_consumed, 0);
    check("reset_done",    done,            1'b0);
    check("reset_timeout", timeout,         1'b0);
    check("reset_halted",  halted,          1'b0);
    check("reset_snap",    snap_regs,       0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_state",   state,   2'd0);
    check("idle_cpu_rst", cpu_rst, 1'b0);

    // Budget run: moving PC ends on the budget in either build
    do_run(1, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef CPU_RUN_MONITOR_HALT_DETECT_EN
    do_run(2, 1, 8,  1'b0, 1'b1, 1'b1, 1'b0); // PC holds at 12 from cycle 4
    do_run(3, 2, 10, 1'b0, 1'b1, 1'b1, 1'b0); // halt and budget on same edge
    do_run(4, 3, 5,  1'b0, 1'b1, 1'b1, 1'b0); // PC frozen from RUN entry
`else
    do_run(2, 1, 10, 1'b1, 1'b0, 1'b1, 1'b0);
    do_run(3, 2, 10, 1'b1, 1'b0, 1'b1, 1'b0);
    do_run(4, 3, 10, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    // start held high: restarts on the edge after DONE entry
    do_run(5, 0, 10, 1'b1, 1'b0, 1'b1, 1'b1);

    // Held-start restart is now in RESET; let it reach cycles_consumed=3 then abort
    pc = 32'h40;
    repeat (2) @(negedge clk);
    check("abort_run_state", state, 2'd2);
    repeat (3) @(negedge clk);
    check("abort_cycles", cycles_consumed, 3);
    #2 rst = 1'b0;
    #1;
    check("abort_state",   state,           2'd0);
    check("abort_cpu_rst", cpu_rst,         1'b0);
    check("abort_cycles0", cycles_consumed, 0);
    check("abort_done",    done,            1'b0);
    check("abort_snap",    snap_regs,       0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_abort_state", state, 2'd0);
    check("pending_runs", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the bench always ends
  initial begin
    #20000;
    $display("FAIL global_timeout: actual=time_expired required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Parametrised run controller and observer for the processor cores. It sequences the core's reset, counts the cycles consumed, and stops the run on a cycle budget or on halt detection (PC stable). It captures a snapshot of N register channels on completion. It sits between the top-level clock/reset and a `processor` instance, so a directed run needs no fixed-delay reset or `MAX_CLOCKS` waits.

## Interface
Parameters:
- `PC_WIDTH`, default 32: width of the observed program counter.
- `CNT_WIDTH`, default 32: width of the cycle counter.
- `MAX_CYCLES`, default 2000: cycle budget per run, range 1 .. 2^CNT_WIDTH-1.
- `RESET_CYCLES`, default 2: number of cycles `cpu_rst` is held low after `start`, minimum 1.
- `HALT_STABLE`, default 4: number of consecutive equal-PC comparisons that declare a halt, minimum 1.
- `NUM_REGS`, default 6: number of observed register channels.
- `REG_WIDTH`, default 32: width of each channel.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a run. Sampled in IDLE and DONE only.
- `pc`  in  PC_WIDTH: core program counter.
- `regs_in`  in  NUM_REGS*REG_WIDTH: flattened register channels, channel k at bits [k*REG_WIDTH +: REG_WIDTH].
- `cpu_rst`  out  1: active-low reset driven to the core.
- `state`  out  2: IDLE=0, RESET=1, RUN=2, DONE=3.
- `cycles_consumed`  out  CNT_WIDTH: number of RUN cycles elapsed.
- `done`  out  1: the run has ended. High throughout DONE.
- `timeout`  out  1: the run ended because the budget was exhausted.
- `halted`  out  1: the run ended because of halt detection.
- `snap_regs`  out  NUM_REGS*REG_WIDTH: register values captured at the end of the run.

## Operation
- Reset (`rst`=0, asynchronous) sets these values:
  - state=IDLE, `cpu_rst`=0.
  - `cycles_consumed`=0.
  - `done`, `timeout`, `halted`=0.
  - `snap_regs`=0.
  - Internal counters cleared.
- All outputs are registered.
- IDLE:
  - `cpu_rst`=0.
  - On `start`=1: go to RESET, load reset counter with RESET_CYCLES-1, clear `cycles_consumed`.
- RESET:
  - `cpu_rst`=0.
  - Reset counter decrements each cycle. At 0, go to RUN; `cpu_rst` goes to 1 on that same edge.
  - `start` is ignored.
- RUN:
  - `cpu_rst`=1.
  - `cycles_consumed` increments by 1 every cycle.
  - If the incremented value equals MAX_CYCLES: go to DONE with `timeout`=1.
  - `start` is ignored.
- Halt detection (macro enabled):
  - `pc_prev` is loaded every RUN cycle and is invalid on the first RUN cycle.
  - `stable_cnt` increments when `pc`==`pc_prev` and `pc_prev` is valid. Otherwise it is cleared to 0.
  - When `stable_cnt` reaches HALT_STABLE: go to DONE with `halted`=1.
- Halt and budget on the same edge: `halted`=1 and `timeout`=0 (halt wins).
- DONE entry edge:
  - `snap_regs` captures `regs_in`.
  - `done`=1.
  - `cycles_consumed` freezes, including the final cycle.
- DONE:
  - `cpu_rst` stays 1. The core keeps running, but its activity is no longer counted.
  - On `start`=1: go to RESET. `done`, `timeout` and `halted` clear on that edge. `snap_regs` holds until the next capture.
- The counter never wraps. The MAX_CYCLES parameter range guarantees termination before overflow.

## Timing
- `start` high at edge N:
  - state=RESET and `cpu_rst`=0 from N.
  - state=RUN and `cpu_rst`=1 from edge N+RESET_CYCLES.
- Budget exhaustion: the first RUN edge sets `cycles_consumed`=1, and `done` rises on the RUN edge that sets `cycles_consumed`=MAX_CYCLES.
- Halt latency: with the PC frozen from the first RUN cycle, `done` rises HALT_STABLE+1 RUN edges after RUN entry.
- Snapshot: `snap_regs` reflects `regs_in` sampled at the DONE entry edge. It is valid while `done`=1.
- Reset mid-run: `rst` low at any point returns the block to IDLE immediately and drives `cpu_rst` low asynchronously. Flags and snapshot clear.
- `start` held high continuously restarts the run from DONE on the edge after DONE entry.

## Configuration
- Macro: `CPU_RUN_MONITOR_HALT_DETECT_EN`.
- Defined: PC-stability halt detection is active as described above.
- Undefined:
  - The `pc_prev` and `stable_cnt` logic is removed.
  - Runs end only on the budget, so `halted` is constant 0.
  - `pc` is unused.

## Test plan
- Reset values: `rst` low with `start`=0 -> all outputs 0 and state=0. After `rst` releases, state stays IDLE and `cpu_rst`=0 until `start`.
- Budget run: MAX_CYCLES=10, RESET_CYCLES=2, `pc` incrementing every cycle, `start` pulsed 1 cycle -> RESET for 2 cycles, RUN for 10 cycles, then `done`=1, `timeout`=1, `halted`=0, `cycles_consumed`=10 held.
- Halt run (macro on): HALT_STABLE=4, `pc` counts 0,4,8,12 then holds at 12 -> `halted`=1, `timeout`=0, `cycles_consumed`=8. `snap_regs` equals `regs_in` at that edge, e.g. channel 2 = 32'h0000_0037.
- Tie: MAX_CYCLES=5, HALT_STABLE=4, `pc` constant from RUN entry -> `done` at `cycles_consumed`=5 with `halted`=1, `timeout`=0.
- Restart and abort:
  - `start` pulsed in DONE -> flags clear, RESET re-entered, `cycles_consumed`=0.
  - `rst` pulsed low at `cycles_consumed`=3 in the new run -> state=IDLE and `cpu_rst`=0 immediately.
- Macro off: constant `pc`, MAX_CYCLES=7 -> run ends only at `cycles_consumed`=7 with `timeout`=1, `halted`=0.
